// File: rtl/spi_slave_fifo.sv
// SPI slave on the system clock with TX/RX FIFOs and valid/ready host ports.
// CPOL/CPHA, bit order and word width are parameters.
module spi_slave_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sck,
  input  logic                          cs_n,
  input  logic                          mosi,
  output logic                          miso,
  output logic                          miso_oe,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          busy,
  output logic                          tx_underrun,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t state, state_d;

  logic [1:0] sck_ff, cs_ff, mosi_ff;
  logic       sck_q, cs_q;
  logic [1:0] fill;
  logic       armed;

  logic cs_fall, cs_rise, sck_chg;
  logic lead, trail, samp_e, drv_e;
  logic xfer, load, shift, samp, done;

  logic [DATA_WIDTH-1:0] tx_sh, rx_sh;
  logic [DATA_WIDTH-1:0] tx_shifted, rx_next;
  logic [CW-1:0]         bit_cnt;
  logic                  tx_bit, pend_ur;

  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]         tx_wr, tx_rd, rx_wr, rx_rd;
  logic [LW-1:0]         tx_cnt, rx_cnt;
  logic                  tx_push, tx_pop, tx_empty;
  logic                  rx_push, rx_pop, rx_full;

  // fill/armed: a cs_n held low across reset must not look like a new select
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_ff  <= {2{CPOL}};
      cs_ff   <= 2'b11;
      mosi_ff <= 2'b00;
      sck_q   <= CPOL;
      cs_q    <= 1'b1;
      fill    <= 2'd0;
      armed   <= 1'b0;
    end else begin
      sck_ff  <= {sck_ff[0], sck};
      cs_ff   <= {cs_ff[0], cs_n};
      mosi_ff <= {mosi_ff[0], mosi};
      sck_q   <= sck_ff[1];
      cs_q    <= cs_ff[1];
      if (fill != 2'd2)
        fill <= fill + 2'd1;
      else if (cs_ff[1])
        armed <= 1'b1;
    end
  end

  assign cs_fall = cs_q & ~cs_ff[1] & armed;
  assign cs_rise = ~cs_q & cs_ff[1];
  assign sck_chg = sck_q ^ sck_ff[1];
  assign lead    = sck_chg & (sck_q == CPOL);
  assign trail   = sck_chg & (sck_ff[1] == CPOL);
  assign samp_e  = CPHA ? trail : lead;
  assign drv_e   = CPHA ? lead : trail;
  assign busy    = ~cs_ff[1];

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (cs_fall) state_d = XFER;
      XFER:    if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miso_oe = 1'b0;
    miso    = 1'b0;
    unique case (state)
      XFER: begin
        miso_oe = 1'b1;
        miso    = tx_bit;
      end
      default: ;
    endcase
  end

  assign xfer  = (state == XFER);
  assign load  = (!CPHA && !xfer && cs_fall) ||
                 (xfer && !cs_rise && drv_e && bit_cnt == '0);
  assign shift = xfer && !cs_rise && drv_e && bit_cnt != '0;
  assign samp  = xfer && !cs_rise && samp_e;
  assign done  = samp && bit_cnt == LAST;

  assign tx_bit     = LSB_FIRST ? tx_sh[0] : tx_sh[DATA_WIDTH-1];
  assign tx_shifted = LSB_FIRST ? {1'b0, tx_sh[DATA_WIDTH-1:1]}
                                : {tx_sh[DATA_WIDTH-2:0], 1'b0};
  assign rx_next    = LSB_FIRST ? {mosi_ff[1], rx_sh[DATA_WIDTH-1:1]}
                                : {rx_sh[DATA_WIDTH-2:0], mosi_ff[1]};

  // Underrun is flagged at the first sample of the word, so the idle
  // reload after a session's final word does not count as a started word.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      pend_ur     <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      tx_underrun <= samp & pend_ur;
      rx_overrun  <= done & rx_full;
      if (load)
        tx_sh <= tx_empty ? '0 : tx_mem[tx_rd];
      else if (shift)
        tx_sh <= tx_shifted;
      if (load)
        pend_ur <= tx_empty;
      else if (cs_rise || samp)
        pend_ur <= 1'b0;
      if (!xfer || cs_rise) begin
        bit_cnt <= '0;
        rx_sh   <= '0;
      end else if (samp) begin
        bit_cnt <= done ? '0 : bit_cnt + CW'(1);
        rx_sh   <= rx_next;
      end
    end
  end

  assign tx_empty = (tx_cnt == '0);
  assign tx_ready = (tx_cnt != FULL);
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = load & ~tx_empty;
  assign tx_level = tx_cnt;

  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      tx_cnt <= tx_cnt + LW'(tx_push) - LW'(tx_pop);
    end
  end

  assign rx_full  = (rx_cnt == FULL);
  assign rx_valid = (rx_cnt != '0);
  assign rx_push  = done & ~rx_full;
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_data  = rx_mem[rx_rd];
  assign rx_level = rx_cnt;

  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wr] <= rx_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      rx_cnt <= rx_cnt + LW'(rx_push) - LW'(rx_pop);
    end
  end

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: five instances cover modes 0-3 and LSB-first,
// with TX/RX word scoreboards and pulse counters.
module tb_spi_slave_fifo;

  localparam int N    = 5;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       sck [N];
  logic       cs_n [N];
  logic       mosi [N];
  logic       miso [N];
  logic       miso_oe [N];
  logic [7:0] tx_data [N];
  logic       tx_valid [N];
  logic       tx_ready [N];
  logic [7:0] rx_data [N];
  logic       rx_valid [N];
  logic       rx_ready [N];
  logic       busy [N];
  logic       tx_underrun [N];
  logic       rx_overrun [N];
  logic [2:0] tx_level [N];
  logic [2:0] rx_level [N];

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int ur_cnt [N];
  int ov_cnt [N];
  int mdl_ur [N];
  int mdl_ov [N];
  bit last_full [N];
  logic [7:0] exp_tx [$];
  logic [7:0] exp_rx [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_slave_fifo #(
      .DATA_WIDTH(8),
      .FIFO_DEPTH(4),
      .CPOL(g == 2 || g == 3),
      .CPHA(g == 1 || g == 3),
      .LSB_FIRST(g == 4)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .sck(sck[g]),
      .cs_n(cs_n[g]),
      .mosi(mosi[g]),
      .miso(miso[g]),
      .miso_oe(miso_oe[g]),
      .tx_data(tx_data[g]),
      .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]),
      .rx_data(rx_data[g]),
      .rx_valid(rx_valid[g]),
      .rx_ready(rx_ready[g]),
      .busy(busy[g]),
      .tx_underrun(tx_underrun[g]),
      .rx_overrun(rx_overrun[g]),
      .tx_level(tx_level[g]),
      .rx_level(rx_level[g])
    );
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (tx_underrun[i] === 1'b1) ur_cnt[i]++;
      if (rx_overrun[i] === 1'b1) ov_cnt[i]++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic bit cpol_of(input int i);
    return (i == 2 || i == 3);
  endfunction

  function automatic bit cpha_of(input int i);
    return (i == 1 || i == 3);
  endfunction

  function automatic bit lsb_of(input int i);
    return (i == 4);
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int i, input string tag);
    check({tag, "_miso"}, 32'(miso[i]), 32'd0);
    check({tag, "_miso_oe"}, 32'(miso_oe[i]), 32'd0);
    check({tag, "_busy"}, 32'(busy[i]), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready[i]), 32'd1);
    check({tag, "_rx_valid"}, 32'(rx_valid[i]), 32'd0);
    check({tag, "_underrun"}, 32'(tx_underrun[i]), 32'd0);
    check({tag, "_overrun"}, 32'(rx_overrun[i]), 32'd0);
    check({tag, "_tx_level"}, 32'(tx_level[i]), 32'd0);
    check({tag, "_rx_level"}, 32'(rx_level[i]), 32'd0);
  endtask

  task automatic push_tx(input int i, input logic [7:0] w);
    check("tx_ready", 32'(tx_ready[i]), 32'(exp_tx.size() < 4));
    tx_data[i]  = w;
    tx_valid[i] = 1'b1;
    clks(1);
    tx_valid[i] = 1'b0;
    exp_tx.push_back(w);
    check("tx_level", 32'(tx_level[i]), 32'(exp_tx.size()));
  endtask

  task automatic cs_lo(input int i);
    last_full[i] = 1'b0;
    cs_n[i] = 1'b0;
    clks(HALF);
  endtask

  task automatic cs_hi(input int i);
    check("busy_sel", 32'(busy[i]), 32'd1);
    check("oe_sel", 32'(miso_oe[i]), 32'd1);
    cs_n[i] = 1'b1;
    clks(4);
    check("oe_release", 32'(miso_oe[i]), 32'd0);
    if (!cpha_of(i) && last_full[i] && exp_tx.size() > 0)
      void'(exp_tx.pop_front());
    clks(4);
    check("underrun_cnt", 32'(ur_cnt[i]), 32'(mdl_ur[i]));
    check("overrun_cnt", 32'(ov_cnt[i]), 32'(mdl_ov[i]));
  endtask

  task automatic spi_word(input int i, input logic [7:0] w,
                          input int nbits);
    logic [7:0] got;
    logic [7:0] exp_m;
    got = 8'h00;
    if (exp_tx.size() > 0) begin
      exp_m = exp_tx.pop_front();
    end else begin
      exp_m = 8'h00;
      mdl_ur[i]++;
    end
    for (int b = 0; b < nbits; b++) begin
      int k;
      k = lsb_of(i) ? b : 7 - b;
      if (!cpha_of(i)) begin
        mosi[i] = w[k];
        clks(HALF);
        sck[i] = ~cpol_of(i);
        got[k] = miso[i];
        clks(HALF);
        sck[i] = cpol_of(i);
      end else begin
        sck[i] = ~cpol_of(i);
        mosi[i] = w[k];
        clks(HALF);
        sck[i] = cpol_of(i);
        got[k] = miso[i];
        clks(HALF);
      end
    end
    last_full[i] = (nbits == 8);
    if (nbits == 8) begin
      check("miso_word", 32'(got), 32'(exp_m));
      if (exp_rx.size() < 4)
        exp_rx.push_back(w);
      else
        mdl_ov[i]++;
    end
  endtask

  task automatic rx_pop_check(input int i);
    logic [7:0] e;
    e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
    check("rx_valid", 32'(rx_valid[i]), 32'd1);
    check("rx_data", 32'(rx_data[i]), 32'(e));
    rx_ready[i] = 1'b1;
    clks(1);
    rx_ready[i] = 1'b0;
  endtask

  initial begin
    logic [7:0] pats [4];
    pats[0] = 8'h81;
    pats[1] = 8'h7E;
    pats[2] = 8'h35;
    pats[3] = 8'hC6;
    for (int i = 0; i < N; i++) begin
      sck[i] = cpol_of(i);
      cs_n[i] = 1'b1;
      mosi[i] = 1'b0;
      tx_data[i] = 8'h00;
      tx_valid[i] = 1'b0;
      rx_ready[i] = 1'b0;
    end
    rst = 1'b1;
    clks(4);
    rst = 1'b0;
    clks(1);
    check_idle(0, "reset");
    clks(4);

    // mode 0 basic exchange
    push_tx(0, 8'hA5);
    cs_lo(0);
    spi_word(0, 8'h3C, 8);
    cs_hi(0);
    check("rx_level_1", 32'(rx_level[0]), 32'(exp_rx.size()));
    rx_pop_check(0);

    // other modes and LSB-first, palindromic and asymmetric patterns
    for (int i = 1; i < N; i++) begin
      for (int p = 0; p < 4; p += 2) begin
        push_tx(i, pats[p]);
        cs_lo(i);
        spi_word(i, pats[p+1], 8);
        cs_hi(i);
        rx_pop_check(i);
      end
    end

    // TX empty: zeros out, one underrun per word
    cs_lo(0);
    spi_word(0, 8'h55, 8);
    spi_word(0, 8'hAA, 8);
    cs_hi(0);
    rx_pop_check(0);
    rx_pop_check(0);

    // RX overrun with depth 4
    cs_lo(0);
    spi_word(0, 8'h11, 8);
    spi_word(0, 8'h22, 8);
    spi_word(0, 8'h33, 8);
    spi_word(0, 8'h44, 8);
    spi_word(0, 8'h55, 8);
    cs_hi(0);
    check("rx_level_full", 32'(rx_level[0]), 32'(exp_rx.size()));
    for (int k = 0; k < 4; k++) rx_pop_check(0);
    check("rx_level_drained", 32'(rx_level[0]), 32'd0);

    // partial word discarded
    cs_lo(0);
    spi_word(0, 8'hFF, 5);
    cs_hi(0);
    check("rx_level_partial", 32'(rx_level[0]), 32'(exp_rx.size()));
    cs_lo(0);
    spi_word(0, 8'h12, 8);
    cs_hi(0);
    check("rx_level_after", 32'(rx_level[0]), 32'(exp_rx.size()));
    rx_pop_check(0);

    // reset mid-word
    push_tx(0, 8'h99);
    cs_lo(0);
    spi_word(0, 8'hF0, 3);
    rst = 1'b1;
    clks(1);
    check_idle(0, "rst_mid");
    exp_tx.delete();
    exp_rx.delete();
    cs_n[0] = 1'b1;
    clks(2);
    rst = 1'b0;
    clks(6);
    check_idle(0, "post_rst");
    push_tx(0, 8'hC3);
    cs_lo(0);
    spi_word(0, 8'h5A, 8);
    cs_hi(0);
    rx_pop_check(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
